// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding an LSB-first serializer.
// The line output comes straight from a flop, so tx has no combinational path from the inputs.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 23000000,
  parameter int BAUD       = 128000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int COUNT_W      = PTR_W + 1;

  localparam logic [CNT_W-1:0]   BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [COUNT_W-1:0] DEPTH_C   = COUNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr_q;
  logic [PTR_W-1:0]   rdPtr_q;
  logic [COUNT_W-1:0] count_q;
  logic               push;
  logic               pop;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bitDone;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign push    = wr_en && !full;
  assign bitDone = (baudCnt_q == BAUD_LAST);
  assign busy    = (state_q != IDLE);
  assign tx      = tx_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= wr_data;
    end
  end

  // The full test uses the pre-edge count, so a write is refused even when a pop lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + COUNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // tx_d carries the level of the bit being entered, so tx changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q + CNT_W'(1);
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        baudCnt_d = '0;
        tx_d      = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rdPtr_q];
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (bitDone) begin
          state_d   = DATA;
          baudCnt_d = '0;
          bitIdx_d  = '0;
          tx_d      = shift_q[0];
        end
      end

      DATA: begin
        if (bitDone) begin
          baudCnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bitIdx_d  = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end
      end

      STOP: begin
        if (bitDone) begin
          baudCnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rdPtr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
    endcase
  end

endmodule
